// File: rtl/char_action_fsm_if.sv
// char_action_fsm_if: frame tick, freeze, buttons and action-state outputs of one player.
interface char_action_fsm_if #(parameter int CNT_W = 5);
  logic frame_tick;
  logic freeze;
  logic btn_left;
  logic btn_right;
  logic btn_attack;
  logic [3:0] state;
  logic attack_active;
  logic busy;
  logic [CNT_W-1:0] phase_cnt;
  modport master (
    output frame_tick, freeze, btn_left, btn_right, btn_attack,
    input state, attack_active, busy, phase_cnt
  );
  modport slave (
    input frame_tick, freeze, btn_left, btn_right, btn_attack,
    output state, attack_active, busy, phase_cnt
  );
endinterface

// File: rtl/char_action_fsm.sv
// char_action_fsm: per-player movement/attack sequencer stepped by frame ticks.
module char_action_fsm #(
  parameter int ATK_START_FR  = 5,
  parameter int ATK_ACTIVE_FR = 2,
  parameter int ATK_RECOV_FR  = 16,
  parameter int DIR_START_FR  = 4,
  parameter int DIR_ACTIVE_FR = 3,
  parameter int DIR_RECOV_FR  = 15,
  parameter int CNT_W         = 5
) (
  input logic clk,
  input logic rst,
  char_action_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    ATK_START  = 4'd3,
    ATK_ACTIVE = 4'd4,
    ATK_RECOV  = 4'd5,
    DIR_START  = 4'd6,
    DIR_ACTIVE = 4'd7,
    DIR_RECOV  = 4'd8
  } state_t;
  state_t st, nxt_st;
  logic [CNT_W-1:0] cnt, nxt_cnt, dec;
  logic atk_prev, atk_req, one_dir, last;
  always_comb begin
    atk_req = bus.btn_attack & ~atk_prev;
    one_dir = bus.btn_left ^ bus.btn_right;
    last = cnt == '0;
    dec = cnt - 1'b1;
    nxt_st = IDLE;
    nxt_cnt = '0;
    case (st)
      IDLE, LEFT, RIGHT: begin
        nxt_st = atk_req ? (one_dir ? DIR_START : ATK_START) : !one_dir ? IDLE : bus.btn_left ? LEFT : RIGHT;
        nxt_cnt = !atk_req ? '0 : one_dir ? CNT_W'(DIR_START_FR - 1) : CNT_W'(ATK_START_FR - 1);
      end
      ATK_START: begin
        nxt_st = last ? ATK_ACTIVE : ATK_START;
        nxt_cnt = last ? CNT_W'(ATK_ACTIVE_FR - 1) : dec;
      end
      ATK_ACTIVE: begin
        nxt_st = last ? ATK_RECOV : ATK_ACTIVE;
        nxt_cnt = last ? CNT_W'(ATK_RECOV_FR - 1) : dec;
      end
      ATK_RECOV: begin
        nxt_st = last ? IDLE : ATK_RECOV;
        nxt_cnt = last ? '0 : dec;
      end
      DIR_START: begin
        nxt_st = last ? DIR_ACTIVE : DIR_START;
        nxt_cnt = last ? CNT_W'(DIR_ACTIVE_FR - 1) : dec;
      end
      DIR_ACTIVE: begin
        nxt_st = last ? DIR_RECOV : DIR_ACTIVE;
        nxt_cnt = last ? CNT_W'(DIR_RECOV_FR - 1) : dec;
      end
      DIR_RECOV: begin
        nxt_st = last ? IDLE : DIR_RECOV;
        nxt_cnt = last ? '0 : dec;
      end
      default: begin
        nxt_st = IDLE;
        nxt_cnt = '0;
      end
    endcase
  end
  // illegal codes fall back to IDLE without waiting for a frame tick
  always_ff @(posedge clk) begin
    if (rst || bus.freeze) begin
      st <= IDLE;
      cnt <= '0;
      atk_prev <= 1'b1;
      bus.attack_active <= 1'b0;
      bus.busy <= 1'b0;
    end else if (bus.frame_tick || st > DIR_RECOV) begin
      st <= nxt_st;
      cnt <= nxt_cnt;
      atk_prev <= bus.frame_tick ? bus.btn_attack : atk_prev;
      bus.attack_active <= nxt_st == ATK_ACTIVE || nxt_st == DIR_ACTIVE;
      bus.busy <= nxt_st >= ATK_START;
    end
  end
  assign bus.state = st;
  assign bus.phase_cnt = cnt;
endmodule

// File: tb/tb_char_action_fsm.sv
// tb_char_action_fsm: directed and random stimulus scored against an elapsed-tick attack model.
module tb_char_action_fsm;
  localparam int S1 = 5, A1 = 2, R1 = 16, S2 = 4, A2 = 3, R2 = 15;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  char_action_fsm_if #(.CNT_W(5)) bus();
  char_action_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  int mode = 0;
  int k = 0;
  int mv = 0;
  bit prev = 1'b1;
  task automatic step(input bit r, input bit f, input bit t, input bit l, input bit rt, input bit a);
    int s, ac, rc, ph, cnt;
    logic [3:0] st;
    rst = r;
    bus.freeze = f;
    bus.frame_tick = t;
    bus.btn_left = l;
    bus.btn_right = rt;
    bus.btn_attack = a;
    if (r || f) begin
      mode = 0;
      k = 0;
      mv = 0;
      prev = 1'b1;
    end else if (t) begin
      if (mode != 0) begin
        k++;
        if (k == (mode == 2 ? S2 + A2 + R2 : S1 + A1 + R1)) begin
          mode = 0;
          mv = 0;
        end
      end else if (a && !prev) begin
        mode = (l ^ rt) ? 2 : 1;
        k = 0;
      end else begin
        mv = (l && !rt) ? 1 : (rt && !l) ? 2 : 0;
      end
      prev = a;
    end
    if (mode == 0) begin
      st = 4'(mv);
      cnt = 0;
      ph = -1;
    end else begin
      s = mode == 2 ? S2 : S1;
      ac = mode == 2 ? A2 : A1;
      rc = mode == 2 ? R2 : R1;
      if (k < s) begin ph = 0; cnt = s - 1 - k; end
      else if (k < s + ac) begin ph = 1; cnt = s + ac - 1 - k; end
      else begin ph = 2; cnt = s + ac + rc - 1 - k; end
      st = 4'((mode == 2 ? 6 : 3) + ph);
    end
    exp_q.push_back({st, ph == 1, mode != 0, 5'(cnt)});
    @(negedge clk);
  endtask
  task automatic tick(input bit l, input bit rt, input bit a);
    step(0, 0, 1, l, rt, a);
    step(0, 0, 0, l, rt, a);
  endtask
  initial begin
    logic [10:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {bus.state, bus.attack_active, bus.busy, bus.phase_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got state=%h act=%b busy=%b cnt=%0d, expected state=%h act=%b busy=%b cnt=%0d",
                   $time, got[10:7], got[6], got[5], got[4:0], e[10:7], e[6], e[5], e[4:0]);
        end
      end
    end
  end
  initial begin
    bit l, rt, a, f;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    repeat (3) tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (25) tick(0, 0, 0);
    tick(1, 0, 1);
    repeat (25) tick(1, 0, 0);
    repeat (60) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (25) tick(0, 0, 0);
    repeat (6) tick(0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    repeat (5) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    repeat (25) tick(0, 0, 0);
    tick(1, 1, 0);
    tick(0, 1, 1);
    repeat (10) tick(0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    repeat (4) step(0, 1, 1, 0, 1, 1);
    repeat (3) tick(0, 1, 1);
    l = 0; rt = 0; a = 0; f = 0;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) l = ~l;
      if ($urandom_range(0, 5) == 0) rt = ~rt;
      if ($urandom_range(0, 4) == 0) a = ~a;
      f = f ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 499) == 0, f, $urandom_range(0, 2) != 0, l, rt, a);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_action_fsm.md
Name: char_action_fsm

Overview:
- Per-player action sequencer. Converts synchronized button levels into the 4-bit state code consumed by the character position handler and by sprite/hitbox logic.
- Movement states step once per frame tick.
- Attacks run fixed startup/active/recovery phases counted in frame ticks. Movement input is locked out for the whole attack.
- One instance per player, clocked by the system clock, advanced by the shared frame_tick strobe.

Parameters:
- ATK_START_FR, 5: basic attack startup length in frame ticks (must be ≥1).
- ATK_ACTIVE_FR, 2: basic attack active length in frame ticks (≥1).
- ATK_RECOV_FR, 16: basic attack recovery length in frame ticks (≥1).
- DIR_START_FR, 4: directional attack startup length in frame ticks (≥1).
- DIR_ACTIVE_FR, 3: directional attack active length in frame ticks (≥1).
- DIR_RECOV_FR, 15: directional attack recovery length in frame ticks (≥1).
- CNT_W, 5: phase counter width. Every *_FR parameter must be ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- frame_tick  input  1  one-clk strobe, once per video frame
- freeze  input  1  round over or paused: force idle and ignore buttons
- btn_left  input  1  left button level, already synchronized/debounced
- btn_right  input  1  right button level, already synchronized/debounced
- btn_attack  input  1  attack button level, already synchronized/debounced
- state  output  4  action state code
- attack_active  output  1  hitbox enable
- busy  output  1  attack sequence in progress
- phase_cnt  output  CNT_W  remaining ticks in current attack phase, minus 1

Behaviour:
- State encodings (fixed, shared with the position handler):
  - IDLE 0000, LEFT 0001, RIGHT 0010
  - ATK_START 0011, ATK_ACTIVE 0100, ATK_RECOV 0101
  - DIR_START 0110, DIR_ACTIVE 0111, DIR_RECOV 1000
- All outputs are registered. Reset values: state=IDLE, attack_active=0, busy=0, phase_cnt=0, internal atk_prev=1.
  - atk_prev=1 means a button held through reset cannot trigger an attack.
- Reset has priority over everything, including mid-attack: the sequence aborts in a single cycle.
- State, phase_cnt and atk_prev change only on cycles with frame_tick=1 (except reset/freeze). With frame_tick=0 all registers hold.
- atk_req = btn_attack & ~atk_prev, sampled on a frame_tick cycle. atk_prev <= btn_attack on every frame_tick. Holding attack therefore yields one attack only; the button must be released for ≥1 tick to re-arm.
- From IDLE, LEFT or RIGHT, on a tick, in this priority order:
  - (1) atk_req with exactly one of btn_left/btn_right high -> DIR_START, phase_cnt=DIR_START_FR-1.
  - (2) atk_req otherwise -> ATK_START, phase_cnt=ATK_START_FR-1.
  - (3) btn_left only -> LEFT.
  - (4) btn_right only -> RIGHT.
  - (5) both or neither -> IDLE.
- In any attack state, on a tick:
  - If phase_cnt≠0: decrement.
  - If phase_cnt=0: advance START->ACTIVE->RECOV and load the next phase length-1. RECOV with phase_cnt=0 -> IDLE.
  - Button levels are ignored. atk_req seen during an attack is discarded, not buffered.
- Phase duration is exactly *_FR ticks: a phase entered on tick N is left on tick N+*_FR.
- Attack-to-IDLE costs one tick. Movement resumes on the following tick.
- attack_active = 1 exactly when state is ATK_ACTIVE or DIR_ACTIVE. busy = 1 for any state code 0011..1000. Both are updated in the same cycle as state.
- freeze=1 (any cycle, no tick needed): state=IDLE, phase_cnt=0, atk_prev<=1. Takes effect next clock and aborts any attack. While freeze is high, frame_tick is ignored.
- Illegal state codes 1001..1111 recover to IDLE on the next clock.
- Arithmetic: phase_cnt is unsigned CNT_W bits. A decrement never occurs at 0, so no wrap.

Test Plan:
- Reset, then btn_right=1 for 3 ticks -> state=0010 after first tick, stays 0010; release -> 0000 on next tick.
- btn_attack rising with no direction -> ATK_START for ticks 1-5, ATK_ACTIVE ticks 6-7 (attack_active=1), ATK_RECOV ticks 8-23, IDLE at tick 24; busy=1 on ticks 1-23.
- btn_left=1 and btn_attack rising on the same tick -> DIR_START (0110) for 4 ticks, DIR_ACTIVE 3 ticks, DIR_RECOV 15 ticks; btn_left held throughout never produces LEFT until after IDLE.
- btn_attack held continuously for 60 ticks -> exactly one attack sequence; release for 1 tick, press again -> second sequence starts.
- rst asserted during ATK_ACTIVE with btn_attack still held -> next clk state=0000, attack_active=0, phase_cnt=0; no new attack until release+press.
- btn_left=btn_right=1, no attack -> IDLE. freeze=1 mid DIR_RECOV with frame_tick=0 -> IDLE next clk, and ticks are ignored while freeze=1.
